// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a uart_tx through a tx_data/tx_valid/tx_ready
// handshake. DEPTH entries (power of two), AW = log2(DEPTH).
// Optional feature: define UART_TX_FIFO_OVF_EN to build the sticky
// write-while-full overflow flag; otherwise overflow is tied low.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic [AW:0]   count,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    assign full     = (count == FULL_CNT);
    assign tx_valid = (count != '0);
    // Head byte is read combinationally so it is stable from valid to the pop edge.
    assign tx_data  = mem[rd_ptr];

    // Handshake qualification: a write needs room as seen before the edge, a pop needs data.
    always_comb begin
        wr_acc = wr_en && !full;
        rd_acc = tx_valid && tx_ready;
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky flag: any write attempt while full is recorded until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH=16): a vector table for the basic
// handshake, then queue-scoreboarded sequences for full, wrap, reset and a
// slow-consumer stream of 256 bytes.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       full;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       overflow;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .count(count), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;
    int         pops = 0;

    typedef struct {
        logic       r;
        logic       we;
        logic [7:0] wd;
        logic       rdy;
        logic [4:0] ecount;
        logic       evalid;
        logic       efull;
        logic [7:0] edata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_ovf();
`ifdef UART_TX_FIFO_OVF_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    // One clock with model update: checks head byte before the edge, state after.
    task automatic step(input logic r, input logic we, input logic [7:0] wd, input logic rdy);
        int sz;
        rst = r; wr_en = we; wr_data = wd; tx_ready = rdy;
        @(negedge clk);
        sz = m_q.size();
        if (!r) begin
            check("valid_pre", {31'd0, tx_valid}, {31'd0, sz > 0});
            if (sz > 0 && rdy) check("pop_data", {24'd0, tx_data}, {24'd0, m_q[0]});
        end
        if (r) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (we && sz == DEPTH) m_ovf = 1'b1;
            if (sz > 0 && rdy) begin
                void'(m_q.pop_front());
                pops++;
            end
            if (we && sz < DEPTH) m_q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check("count", {27'd0, count}, m_q.size());
        check("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        check("valid", {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
        check("overflow", {31'd0, overflow}, {31'd0, exp_ovf()});
    endtask

    int next_w;
    int cyc;
    logic wen;

    initial begin
        // r we wd rdy | count valid full data
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 5'd1, 1'b1, 1'b0, 8'h41};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 8'h41};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 8'h12, 1'b0, 5'd1, 1'b1, 1'b0, 8'h12};
        vecs[5] = '{1'b0, 1'b1, 8'h34, 1'b1, 5'd1, 1'b1, 1'b0, 8'h34};
        vecs[6] = '{1'b0, 1'b1, 8'h56, 1'b0, 5'd2, 1'b1, 1'b0, 8'h34};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 1'b0, 8'h56};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 1'b1, 8'h99, 1'b1, 5'd1, 1'b1, 1'b0, 8'h99};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].r; wr_en = vecs[i].we; wr_data = vecs[i].wd; tx_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, vecs[i].ecount});
            check($sformatf("vec%0d_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].evalid});
            check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].efull});
            check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
            if (vecs[i].evalid) check($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].edata});
        end

        // Fill to full, write while full, then write+pop at the full edge.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        check("full_count16", {27'd0, count}, 32'd16);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        check("after_fullpop", {27'd0, count}, 32'd15);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Three bytes held while streaming through a wrap.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
        check("steady_count3", {27'd0, count}, 32'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-operation discards buffered bytes.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_count", {27'd0, count}, 32'd0);
        step(1'b0, 1'b1, 8'h7E, 1'b0);
        check("rst_head", {24'd0, tx_data}, 32'h7E);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Producer faster than a slow consumer, gated by full.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        pops = 0;
        next_w = 0;
        cyc = 0;
        while ((next_w < 256 || m_q.size() > 0) && cyc < 6000) begin
            wen = (next_w < 256) && !full;
            step(1'b0, wen, 8'(next_w), (cyc % 10) == 9);
            if (wen) next_w++;
            cyc++;
        end
        check("stream_pops", pops, 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL: parameter DEPTH, default 16, number of byte entries; legal values are powers of two, 4 to 256.
REQ-002 SHALL: parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL: rst, input, 1, synchronous active-high reset.
REQ-005 SHALL: wr_data, input, 8, byte from the producer.
REQ-006 SHALL: wr_en, input, 1, write request, sampled at the rising edge.
REQ-007 SHALL: full, output, 1, high when count == DEPTH.
REQ-008 SHALL: count, output, AW+1, number of stored bytes, 0..DEPTH.
REQ-009 SHALL: tx_data, output, 8, head byte presented to uart_tx.
REQ-010 SHALL: tx_valid, output, 1, high when count != 0.
REQ-011 SHALL: tx_ready, input, 1, high when uart_tx can accept a byte.
REQ-012 SHALL: overflow, output, 1, sticky write-while-full flag (see Configuration).

Function
REQ-013 SHALL: act as the producer side of the uart_tx tx_data/tx_valid/tx_ready interface, backed by a DEPTH-entry circular byte buffer.
REQ-014 SHALL: accept a write at an edge where wr_en=1 and full=0 (full as sampled before that edge), storing wr_data at wr_ptr and incrementing wr_ptr modulo DEPTH.
REQ-015 SHALL: perform a pop at an edge where tx_valid=1 and tx_ready=1, incrementing rd_ptr modulo DEPTH.
REQ-016 SHALL: drive tx_data combinationally from the entry at rd_ptr, so it is stable from tx_valid rising until the pop edge.
REQ-017 SHALL: give a one-cycle write-to-valid latency; a byte written into an empty FIFO at edge N raises tx_valid after edge N.
REQ-018 SHALL: update count as +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
REQ-019 SHALL: when full, reject a write even if a pop occurs at the same edge; the pop proceeds and count becomes DEPTH-1.
REQ-020 SHALL: when empty, treat tx_ready as don't-care; no pop occurs and count and pointers are unchanged apart from a write.
REQ-021 SHALL: when a write is rejected, leave the stored data, the pointers and count unchanged.
REQ-022 SHALL: wrap pointers from DEPTH-1 to 0 with no loss or reordering; output order is strict FIFO.
REQ-023 SHALL: keep tx_valid high while count>0 and never deassert it without a pop.

Reset
REQ-024 SHALL: at an edge where rst=1, set wr_ptr=0, rd_ptr=0, count=0, tx_valid=0, full=0 and overflow=0; this takes priority over a simultaneous write or pop.
REQ-025 SHALL: not reset storage contents; tx_data is don't-care while tx_valid=0.
REQ-026 SHALL: on reset mid-operation, discard all buffered bytes; the first write after reset is the first byte popped.

Configuration
REQ-027 SHALL: with macro UART_TX_FIFO_OVF_EN defined, set overflow to 1 on any edge with wr_en=1 and full=1, holding it until rst.
REQ-028 SHALL: with UART_TX_FIFO_OVF_EN undefined, keep the overflow port but tie it to constant 0 and include no overflow logic.

Verification
REQ-029 SHALL: cover: after reset, write 0x41 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0x41, count=1; raise tx_ready for one edge -> tx_valid=0, count=0.
REQ-030 SHALL: cover: write 0x00..0x0F (DEPTH=16) with tx_ready=0 -> full=1, count=16; write 0xAA -> count stays 16, 0xAA is never output, and overflow=1 only with UART_TX_FIFO_OVF_EN defined.
REQ-031 SHALL: cover: full FIFO, wr_en=1 with 0x55 and tx_ready=1 at the same edge -> 0x00 popped, 0x55 dropped, count=15, full=0.
REQ-032 SHALL: cover: count=3, simultaneous write and pop for 40 cycles -> count stays 3, and all bytes emerge in order across pointer wrap.
REQ-033 SHALL: cover: 5 bytes buffered, rst pulsed for one cycle -> tx_valid=0, count=0, overflow=0; then write 0x7E -> next tx_data=0x7E.
REQ-034 SHALL: cover: connect to uart_tx and uart_rx in loopback and write 0x00..0xFF at a faster rate than the line rate, gated by full -> uart_rx outputs all 256 bytes in order.
